keypad_debouncer: RTL and testbench
===================================

Name: keypad_debouncer

Overview:
- Sits directly downstream of the keypad scanner; consumes its raw pressed_row/pressed_col/press outputs.
- Debounces press and release and locks out other keys while one is held.
- On each accepted press, emits a one-cycle key_valid pulse with the decoded hex digit.
- Maintains a two-digit history (newest, previous) that drives the dual seven-segment display.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a press or a release (must be >= 1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- press  input  1  scanner reports a key closed this cycle
- pressed_row  input  2  row index of closed key, valid when press=1
- pressed_col  input  2  column index of closed key, valid when press=1
- key_valid  output  1  one-cycle pulse: new debounced key accepted
- key_code  output  4  hex code of most recently accepted key
- digit_new  output  4  newest digit for display
- digit_old  output  4  previous digit for display
- key_held  output  1  high while a debounced key is considered held

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high. Inputs are synchronous to clk (scanner output); no internal synchronizer.
- Reset, applied immediately regardless of clk:
  - state=IDLE, counter=0, candidate=0.
  - key_valid=0, key_code=0, digit_new=0, digit_old=0, key_held=0.
- All outputs are registered.
- Keymap (row,col -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
- IDLE:
  - press=1 -> capture {row,col} as candidate, counter=0, go DB_PRESS.
- DB_PRESS:
  - press=1 and {row,col}==candidate, counter<DEBOUNCE_CYCLES-1 -> counter++.
  - press=1, match, counter==DEBOUNCE_CYCLES-1 -> go HELD. Same edge: key_valid<=1, key_code<=code, digit_old<=digit_new, digit_new<=code.
  - press=0 or key mismatch -> IDLE. No pulse, history unchanged.
- HELD:
  - key_held=1.
  - press=0 -> DB_RELEASE, counter=0.
  - press=1 with any key (including a different one) -> stay HELD, no event.
- DB_RELEASE:
  - key_held stays 1.
  - press=0, counter<DEBOUNCE_CYCLES-1 -> counter++.
  - press=0, counter==DEBOUNCE_CYCLES-1 -> IDLE, key_held<=0.
  - press=1 (any key) -> HELD, counter=0, no new event (bounce lock-out).
- Latency: key_valid rises DEBOUNCE_CYCLES rising edges after the capture edge (DEBOUNCE_CYCLES+1 edges counting capture). Pulse lasts exactly one cycle.
- DEBOUNCE_CYCLES=1: accept on the first edge after capture.
- Counter is never compared beyond DEBOUNCE_CYCLES-1; no wrap.
- key_valid is asserted at most once per IDLE->HELD traversal.
- Reset mid-debounce: pending candidate discarded; a fresh full debounce is required.

Decomposition:
- keypad_pkg:
  - state enum kp_state_t {IDLE, DB_PRESS, HELD, DB_RELEASE}
  - 4x4 keymap constant array KEYMAP[row][col] of logic [3:0]
- Sub-module keypad_keymap: combinational {row,col} -> 4-bit code, reusing KEYMAP. Shared with future display/test logic.

Test Plan (DEBOUNCE_CYCLES=8):
1. Reset, then hold press=1 at row1 col1 for 20 cycles -> one key_valid pulse on the 8th edge after capture; key_code=5, digit_new=5, digit_old=0, key_held=1.
2. press=1 at row2 col2 for 3 cycles, then 0 -> no key_valid; key_held=0; digits unchanged.
3. While holding '5', switch to row2 col0 for 10 cycles -> no pulse, key_code stays 5, key_held=1.
4. Holding '5': drop press 3 cycles, raise 2 cycles, release 10 cycles -> no extra pulse, key_held=0. Then press row0 col3 for 12 cycles -> key_valid once, digit_new=A, digit_old=5.
5. Press row3 col0 and accept, release, then press row3 col3 and accept -> key_code E then D; digit_new=D, digit_old=E.
6. Assert reset 4 cycles into DB_PRESS, deassert with press still high -> all outputs 0 immediately. No pulse until 8 further stable edges after the new capture.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad debounce path.
//   kp_state_t : debouncer FSM states
//   KEYMAP     : 4x4 key matrix, indexed [row][col], giving the 4-bit hex code
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_t;

    // Row 3 is the odd one out: E 0 F D
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/keypad_keymap.sv
// Combinational key decoder: {row,col} of a closed key -> hex code.
//   row  in  2  row index
//   col  in  2  column index
//   code out 4  hex code from KEYMAP
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [3:0] code
);

    assign code = KEYMAP[row][col];

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces scanner press/release, locks out other keys while one is held,
// pulses key_valid once per accepted key and keeps a two-digit history.
//   clk, reset              clock, async active-high reset
//   press, pressed_row/col  raw scanner outputs (synchronous to clk)
//   key_valid               one-cycle pulse on an accepted press
//   key_code                code of the most recently accepted key
//   digit_new, digit_old    display history (newest, previous)
//   key_held                high from acceptance until a debounced release
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic [1:0] pressed_row,
    input  logic [1:0] pressed_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    kp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;       // {row,col} being debounced
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;
    logic             key_held_q, key_held_d;

    logic [3:0] cand_code;
    logic       match;
    logic       cnt_last;

    keypad_keymap u_keymap (
        .row  (cand_q[3:2]),
        .col  (cand_q[1:0]),
        .code (cand_code)
    );

    assign match    = press && ({pressed_row, pressed_col} == cand_q);
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        key_held_d  = key_held_q;

        case (state_q)
            IDLE: begin
                if (press) begin
                    cand_d  = {pressed_row, pressed_col};
                    cnt_d   = '0;
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!match) begin
                    // bounce or a different key: drop the candidate entirely
                    state_d = IDLE;
                end else if (cnt_last) begin
                    state_d     = HELD;
                    key_valid_d = 1'b1;
                    key_code_d  = cand_code;
                    digit_old_d = digit_new_q;
                    digit_new_d = cand_code;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                // any closure, even another key, just keeps us held
                if (!press) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE: begin
                if (press) begin
                    // release bounce: back to held without a new event
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d    = IDLE;
                    key_held_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Self-checking bench for keypad_debouncer with DEBOUNCE_CYCLES=8.
// A run-length model predicts every registered output; directed scenarios
// add literal checks on timing, codes and history.
module tb_keypad_debouncer;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       press;
    logic [1:0] pressed_row;
    logic [1:0] pressed_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_held;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .press       (press),
        .pressed_row (pressed_row),
        .pressed_col (pressed_col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .digit_new   (digit_new),
        .digit_old   (digit_old),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] hex_of(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a press is accepted after D+1 consecutive edges of the same key
    // (counting the edge that first sees it); a release after D+1
    // consecutive edges without any press. A mismatch resets the run to zero.
    int         run = 0;
    int         rel = 0;
    logic [3:0] cand_m = 0;
    logic       m_valid = 0, m_held = 0;
    logic [3:0] m_code = 0, m_new = 0, m_old = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            run = 0; rel = 0; cand_m = 0;
            m_valid = 0; m_held = 0; m_code = 0; m_new = 0; m_old = 0;
        end else begin
            m_valid = 0;
            if (!m_held) begin
                if (run == 0) begin
                    if (press) begin
                        run    = 1;
                        cand_m = {pressed_row, pressed_col};
                    end
                end else if (press && {pressed_row, pressed_col} == cand_m) begin
                    run++;
                    if (run == D + 1) begin
                        m_valid = 1;
                        m_code  = hex_of(cand_m[3:2], cand_m[1:0]);
                        m_old   = m_new;
                        m_new   = m_code;
                        m_held  = 1;
                        run     = 0;
                        rel     = 0;
                    end
                end else begin
                    run = 0;
                end
            end else begin
                if (press) rel = 0;
                else begin
                    rel++;
                    if (rel == D + 1) begin
                        m_held = 0;
                        rel    = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        chk("key_code",  key_code,  m_code);
        chk("digit_new", digit_new, m_new);
        chk("digit_old", digit_old, m_old);
        chk("key_held",  {3'b0, key_held}, {3'b0, m_held});
        if (key_valid === 1'b1) pulses++;
    end

    task automatic drive(input logic p, input logic [1:0] r, input logic [1:0] c, input int n);
        press = p; pressed_row = r; pressed_col = c;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; press = 1'b0; pressed_row = 2'd0; pressed_col = 2'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {3'b0, key_valid}, 4'h0);
        chk("rst_code",  key_code,  4'h0);
        chk("rst_new",   digit_new, 4'h0);
        chk("rst_old",   digit_old, 4'h0);
        chk("rst_held",  {3'b0, key_held}, 4'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: hold '5'; pulse lands on the 8th edge after capture
        drive(1, 2'd1, 2'd1, 8);
        #1 chk("t1_pre_valid", {3'b0, key_valid}, 4'h0);
        @(negedge clk);
        #1;
        chk("t1_valid", {3'b0, key_valid}, 4'h1);
        chk("t1_code",  key_code,  4'h5);
        chk("t1_new",   digit_new, 4'h5);
        chk("t1_old",   digit_old, 4'h0);
        chk("t1_held",  {3'b0, key_held}, 4'h1);
        drive(1, 2'd1, 2'd1, 11);
        #1 chk("t1_pulses", 4'(pulses), 4'd1);

        // 3: another key while held is locked out
        drive(1, 2'd2, 2'd0, 10);
        #1;
        chk("t3_pulses", 4'(pulses), 4'd1);
        chk("t3_code",   key_code, 4'h5);
        chk("t3_held",   {3'b0, key_held}, 4'h1);

        // 4: release bounce, full release, then 'A'
        drive(0, 2'd0, 2'd0, 3);
        drive(1, 2'd1, 2'd1, 2);
        drive(0, 2'd0, 2'd0, 10);
        #1;
        chk("t4_held",   {3'b0, key_held}, 4'h0);
        chk("t4_pulses", 4'(pulses), 4'd1);
        drive(1, 2'd0, 2'd3, 12);
        #1;
        chk("t4_pulses2", 4'(pulses), 4'd2);
        chk("t4_code",    key_code,  4'hA);
        chk("t4_new",     digit_new, 4'hA);
        chk("t4_old",     digit_old, 4'h5);
        drive(0, 2'd0, 2'd0, 12);

        // 2: short press is rejected
        drive(1, 2'd2, 2'd2, 3);
        drive(0, 2'd0, 2'd0, 12);
        #1;
        chk("t2_pulses", 4'(pulses), 4'd2);
        chk("t2_held",   {3'b0, key_held}, 4'h0);
        chk("t2_new",    digit_new, 4'hA);
        chk("t2_old",    digit_old, 4'h5);

        // 5: 'E' then 'D'
        drive(1, 2'd3, 2'd0, 10);
        #1 chk("t5_code_e", key_code, 4'hE);
        drive(0, 2'd0, 2'd0, 12);
        drive(1, 2'd3, 2'd3, 10);
        #1;
        chk("t5_code_d", key_code,  4'hD);
        chk("t5_new",    digit_new, 4'hD);
        chk("t5_old",    digit_old, 4'hE);
        chk("t5_pulses", 4'(pulses), 4'd4);
        drive(0, 2'd0, 2'd0, 12);

        // 6: reset mid-debounce, press stays high through reset
        drive(1, 2'd1, 2'd1, 5);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {3'b0, key_valid}, 4'h0);
        chk("t6_rst_code",  key_code,  4'h0);
        chk("t6_rst_new",   digit_new, 4'h0);
        chk("t6_rst_old",   digit_old, 4'h0);
        chk("t6_rst_held",  {3'b0, key_held}, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("t6_pre_valid", {3'b0, key_valid}, 4'h0);
        chk("t6_pulses",    4'(pulses), 4'd4);
        @(negedge clk);
        #1;
        chk("t6_valid", {3'b0, key_valid}, 4'h1);
        chk("t6_code",  key_code,  4'h5);
        chk("t6_new",   digit_new, 4'h5);
        chk("t6_old",   digit_old, 4'h0);
        drive(0, 2'd0, 2'd0, 12);
        #1 chk("t6_end_held", {3'b0, key_held}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
